vliw_fetch_stage: RTL



---
 rtl/vliw_pkg.sv | 17 +
 rtl/fetch_redirect_sel.sv | 46 ++++
 rtl/vliw_fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared types and constants for the dual-issue VLIW front end.
// Bundle layout: ALU-slot instruction in the upper half, MEM-slot in the lower.
package vliw_pkg;

  localparam int          INSTR_W   = 16;
  localparam int          BUNDLE_W  = 32;
  localparam int          PC_W      = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] alu_instr;
    logic [INSTR_W-1:0] mem_instr;
    logic [PC_W-1:0]    pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect request and target select for the fetch stage.
// FETCH_ALIGN_CHECK_EN: misaligned targets fall back to the exception vector.
module fetch_redirect_sel #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        is_exception,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        flag_n,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] target
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  logic [31:0] raw_target;

  assign redirect = is_exception | is_jump
                  | (is_branch & flag_n);

  // Several sources may fire together, so this is a priority chain.
  always_comb begin
    raw_target = branch_target;
    if (is_exception) begin
      raw_target = EXC_VECTOR;
    end else if (is_jump) begin
      raw_target = jump_target;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    align_fault = redirect
                & (raw_target[1:0] != 2'b00);
    target      = align_fault ? EXC_VECTOR
                              : raw_target;
  end
`else
  assign target = raw_target;
`endif

endmodule

// File: rtl/vliw_fetch_stage.sv
// IF stage: PC, 1-cycle imem fetch, one-entry skid buffer, IF/ID register.
// FETCH_ALIGN_CHECK_EN adds p1_fetch_fault for misaligned redirect targets.
module vliw_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [15:0] NOP_INSTR  = vliw_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_pipeline_regWrite,
  input  logic        pcWrite,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  input  logic        isBranch,
  input  logic        p2_alu_flag_N,
  input  logic        isJump,
  input  logic        isException,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [15:0] p1_alu_instr,
  output logic [15:0] p1_mem_instr,
  output logic [31:0] p1_pc,
  output logic        p1_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        p1_fetch_fault
`endif
);

  import vliw_pkg::*;

  logic          redirect;
  logic [31:0]   target;
  logic [31:0]   pc;
  logic          pending;
  logic [31:0]   pending_pc;
  fetch_bundle_t skid;
  logic          skid_valid;
  fetch_bundle_t p1;
  logic          p1_valid_q;
  logic          issue;
  fetch_bundle_t resp;
  fetch_bundle_t nop_b;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_fault;
`endif

  fetch_redirect_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_sel (
    .is_exception (isException),
    .is_jump      (isJump),
    .is_branch    (isBranch),
    .flag_n       (p2_alu_flag_N),
    .branch_target(branchTarget),
    .jump_target  (jumpTarget),
    .redirect     (redirect),
    .target       (target)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_fault  (align_fault)
`endif
  );

  // A full skid blocks issue so the drain cycle never overlaps a response.
  assign issue = pcWrite & p1_pipeline_regWrite
               & ~skid_valid & ~redirect & ~reset;

  assign imem_en   = issue;
  assign imem_addr = pc;

  always_comb begin
    resp.alu_instr  = imem_rdata[BUNDLE_W-1:INSTR_W];
    resp.mem_instr  = imem_rdata[INSTR_W-1:0];
    resp.pc         = pending_pc;
    nop_b.alu_instr = NOP_INSTR;
    nop_b.mem_instr = NOP_INSTR;
    nop_b.pc        = p1.pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      pending        <= 1'b0;
      pending_pc     <= RESET_PC;
      skid_valid     <= 1'b0;
      p1.alu_instr   <= NOP_INSTR;
      p1.mem_instr   <= NOP_INSTR;
      p1.pc          <= RESET_PC;
      p1_valid_q     <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pc         <= pc + PC_INC;
        pending_pc <= pc;
      end
      if (redirect) begin
        pc         <= target;
        skid_valid <= 1'b0;
        p1         <= nop_b;
        p1_valid_q <= 1'b0;
      end else if (p1_pipeline_regWrite) begin
        if (pending) begin
          p1         <= resp;
          p1_valid_q <= 1'b1;
        end else if (skid_valid) begin
          p1         <= skid;
          p1_valid_q <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          p1         <= nop_b;
          p1_valid_q <= 1'b0;
        end
      end else if (pending) begin
        skid       <= resp;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_fetch_fault <= 1'b0;
    end else begin
      p1_fetch_fault <= redirect & align_fault;
    end
  end
`endif

  assign p1_alu_instr = p1.alu_instr;
  assign p1_mem_instr = p1.mem_instr;
  assign p1_pc        = p1.pc;
  assign p1_valid     = p1_valid_q;

endmodule
